// File: rtl/bus_pkt_fifo.sv
// Bus-to-packet FIFO: accepted writes enqueue {addr,data}; reads are only counted. Latency 1 cycle bus->pkt (fall-through head).
// Backpressure: bus_ready is registered and drops while the FIFO is full; pkt side is plain valid/ready.
module bus_pkt_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_valid,
    output logic                     bus_ready,
    input  logic [ADDR_WIDTH-1:0]    bus_addr,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    input  logic                     bus_write_enable,
    output logic                     pkt_valid,
    input  logic                     pkt_ready,
    output logic [ADDR_WIDTH-1:0]    pkt_id,
    output logic [DATA_WIDTH-1:0]    pkt_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rd_ignored
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               bus_ready_q, bus_ready_d;
    logic [7:0]         rd_cnt_q, rd_cnt_d;
    logic               accept, push, pop;

    always_comb begin
        accept   = bus_valid && bus_ready_q;
        push     = accept && bus_write_enable;
        pop      = (level_q != '0) && pkt_ready;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // Ready is computed from next occupancy so it reopens the cycle after a pop from full.
        bus_ready_d = (level_d != FULL_LVL);
        rd_cnt_d    = rd_cnt_q;
        if (accept && !bus_write_enable && (rd_cnt_q != 8'hFF)) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            bus_ready_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            bus_ready_q <= bus_ready_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // Storage needs no reset: nothing is visible unless level_q says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{id: bus_addr, data: bus_data};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign bus_ready  = bus_ready_q;
    assign pkt_valid  = (level_q != '0);
    assign pkt_id     = pkt_valid ? head.id   : '0;
    assign pkt_data   = pkt_valid ? head.data : '0;
    assign level      = level_q;
    assign rd_ignored = rd_cnt_q;
endmodule

// File: tb/tb_bus_pkt_fifo.sv
// Directed + random bench for bus_pkt_fifo against a queue-based reference model.
module tb_bus_pkt_fifo;
    localparam int AW    = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_valid = 1'b0;
    logic          bus_ready;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_data = '0;
    logic          bus_write_enable = 1'b0;
    logic          pkt_valid;
    logic          pkt_ready = 1'b0;
    logic [AW-1:0] pkt_id;
    logic [DW-1:0] pkt_data;
    logic [$clog2(DEPTH):0] level;
    logic [7:0]    rd_ignored;

    typedef struct {
        logic [AW-1:0] id;
        logic [DW-1:0] data;
    } pkt_t;

    pkt_t q[$];
    int   m_rd = 0;
    bit   m_ready = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    bus_pkt_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_write_enable(bus_write_enable),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_id(pkt_id),
        .pkt_data(pkt_data), .level(level), .rd_ignored(rd_ignored)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " bus_ready"},  64'(bus_ready),  64'(m_ready));
        chk({tag, " level"},      64'(level),      64'(q.size()));
        chk({tag, " pkt_valid"},  64'(pkt_valid),  64'(q.size() > 0));
        chk({tag, " rd_ignored"}, 64'(rd_ignored), 64'(m_rd));
        if (q.size() > 0) begin
            chk({tag, " pkt_id"},   64'(pkt_id),   64'(q[0].id));
            chk({tag, " pkt_data"}, 64'(pkt_data), 64'(q[0].data));
        end
    endtask

    // One clock: decide transfers from pre-edge state, advance model, check after the edge.
    task automatic cycle(input string tag);
        bit   acc, push, pop;
        pkt_t p;
        acc  = bus_valid && m_ready;
        push = acc && bus_write_enable;
        pop  = (q.size() > 0) && pkt_ready;
        p.id   = bus_addr;
        p.data = bus_data;
        @(posedge clk);
        #1;
        if (pop) q.delete(0);
        if (push) q.push_back(p);
        if (acc && !bus_write_enable && m_rd < 255) m_rd++;
        m_ready = (q.size() < DEPTH);
        check_outputs(tag);
    endtask

    task automatic drain();
        bus_valid = 1'b0;
        pkt_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) cycle("drain");
        chk("drain empty", 64'(level), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset pkt_id",   64'(pkt_id),   64'd0);
        chk("reset pkt_data", 64'(pkt_data), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-release ready before edge", 64'(bus_ready), 64'd0);
        cycle("first edge");
        chk("ready after first edge", 64'(bus_ready), 64'd1);

        // Single write
        bus_valid = 1'b1; bus_write_enable = 1'b1; bus_addr = 32'h10; bus_data = 16'h1234; pkt_ready = 1'b1;
        cycle("single push");
        chk("single pkt_id",   64'(pkt_id),   64'h10);
        chk("single pkt_data", 64'(pkt_data), 64'h1234);
        chk("single level1",   64'(level),    64'd1);
        bus_valid = 1'b0;
        cycle("single pop");
        chk("single level0",   64'(level),    64'd0);

        // Fill beyond capacity
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_valid = 1'b1; bus_addr = AW'(i); bus_data = DW'(i);
            cycle("fill");
        end
        chk("fill level4", 64'(level), 64'd4);
        chk("fill ready0", 64'(bus_ready), 64'd0);
        pkt_ready = 1'b1;
        cycle("fill pop0");
        chk("fill head after pop", 64'(pkt_data), 64'd1);
        chk("fill ready back",     64'(bus_ready), 64'd1);
        chk("fill level3",         64'(level),     64'd3);
        cycle("fill 5th accepted");
        drain();

        // Streaming with simultaneous push/pop at level 1
        pkt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_valid = 1'b1; bus_write_enable = 1'b1;
            bus_addr = $urandom; bus_data = DW'($urandom);
            cycle("stream");
            chk("stream level1", 64'(level), 64'd1);
        end
        drain();

        // Reads only count, saturating
        bus_valid = 1'b1; bus_write_enable = 1'b0; pkt_ready = 1'b1;
        for (int i = 0; i < 300; i++) cycle("reads");
        chk("reads saturated", 64'(rd_ignored), 64'd255);
        chk("reads no pkt",    64'(pkt_valid),  64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus_valid        = 1'($urandom_range(0, 1));
            bus_write_enable = ($urandom_range(0, 3) != 0);
            pkt_ready        = ($urandom_range(0, 2) != 0);
            bus_addr         = $urandom;
            bus_data         = DW'($urandom);
            cycle("random");
        end
        drain();

        // Reset mid-run discards queued entries
        pkt_ready = 1'b0; bus_write_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_valid = 1'b1; bus_addr = 32'hA0 + AW'(i); bus_data = 16'hBEE0 + DW'(i);
            cycle("pre-reset fill");
        end
        bus_valid = 1'b0;
        chk("pre-reset level3", 64'(level), 64'd3);
        #2 rst = 1'b1;
        #1;
        q.delete();
        m_rd = 0;
        m_ready = 1'b0;
        check_outputs("mid reset");
        chk("mid reset pkt_id",   64'(pkt_id),   64'd0);
        chk("mid reset pkt_data", 64'(pkt_data), 64'd0);
        #2 rst = 1'b0;
        pkt_ready = 1'b1;
        repeat (3) cycle("after reset");
        bus_valid = 1'b1; bus_write_enable = 1'b1; bus_addr = 32'h55; bus_data = 16'h7777;
        cycle("fresh write");
        chk("fresh pkt_id", 64'(pkt_id), 64'h55);
        bus_write_enable = 1'b0;
        repeat (3) cycle("fresh reads");
        chk("fresh rd count", 64'(rd_ignored), 64'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_pkt_fifo.md
BUS_PKT_FIFO -- requirements
Module: bus_pkt_fifo

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning bus address width and packet id width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning bus data width and packet data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 The block SHALL have port bus_valid  input  1  upstream bus master request valid.
REQ-007 The block SHALL have port bus_ready  output  1  follower ready; a transfer occurs when bus_valid && bus_ready at a clk edge.
REQ-008 The block SHALL have port bus_addr  input  ADDR_WIDTH  request address.
REQ-009 The block SHALL have port bus_data  input  DATA_WIDTH  write data.
REQ-010 The block SHALL have port bus_write_enable  input  1  1 = write, 0 = read.
REQ-011 The block SHALL have port pkt_valid  output  1  downstream packet valid.
REQ-012 The block SHALL have port pkt_ready  input  1  downstream consumer ready; a pop occurs when pkt_valid && pkt_ready at a clk edge.
REQ-013 The block SHALL have port pkt_id  output  ADDR_WIDTH  head packet id.
REQ-014 The block SHALL have port pkt_data  output  DATA_WIDTH  head packet data.
REQ-015 The block SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 The block SHALL have port rd_ignored  output  8  saturating count of accepted read requests.

Function
REQ-017 bus_ready SHALL be 1 exactly when level < DEPTH and rst is low; it SHALL be derived from registered state only, with no combinational path from bus_valid or pkt_ready.
REQ-018 An accepted write SHALL push the entry {id = bus_addr, data = bus_data} at the FIFO tail.
REQ-019 An accepted read (bus_write_enable = 0) SHALL NOT push; rd_ignored SHALL increment by 1, saturating at 255.
REQ-020 pkt_valid SHALL be 1 exactly when level > 0; pkt_id/pkt_data SHALL present the oldest entry (first-word fall-through).
REQ-021 A pushed entry SHALL appear on pkt_* (or move up the queue) one cycle after the accepting edge; minimum bus-to-pkt latency is 1 cycle.
REQ-022 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-023 Simultaneous push and pop SHALL leave level unchanged and keep order, including at level = 1.
REQ-024 Push alone SHALL increment level; pop alone SHALL decrement level.
REQ-025 When level = DEPTH, bus_ready SHALL be 0 and bus_valid SHALL be ignored, regardless of pkt_ready that cycle; ready SHALL return the cycle after a pop.
REQ-026 When level = 0, pkt_ready SHALL have no effect.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH without a gap or extra entry.
REQ-028 pkt_id/pkt_data SHALL hold stable while pkt_valid && !pkt_ready.

Reset
REQ-029 While rst is high, asynchronously: level = 0, pointers = 0, pkt_valid = 0, bus_ready = 0, rd_ignored = 0, pkt_id = 0, pkt_data = 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; no stale packet SHALL appear after release.
REQ-031 bus_ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-032 Single write: addr=0x10, data=0x1234, pkt_ready=1 -> next cycle pkt_valid=1, pkt_id=0x10, pkt_data=0x1234; level 1 then 0.
REQ-033 Fill: 5 writes with pkt_ready=0, DEPTH=4 -> four accepted (level=4), bus_ready=0 on the 5th; raise pkt_ready -> data 0,1,2,3 in order, 5th accepted after first pop.
REQ-034 Streaming: back-to-back writes with pkt_ready=1 for 10 cycles -> level stays 1, all 10 packets emerge in order, pointers wrap twice.
REQ-035 Reads: 300 accepted reads -> no pkt_valid, rd_ignored saturates at 255.
REQ-036 Reset mid-run: 3 entries queued, pulse rst between edges -> pkt_valid=0, level=0 immediately; no old data emerges after release.
